// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: latches N interrupt requests, arbitrates by priority, presents one vector at a time with valid/ack; optional ack timeout via IRQ_SRC_ACK_TIMEOUT_EN
module irq_source_ctrl #(
  parameter int N = 32,
  parameter int PRIO_W = 0,
  parameter int EDGE_MODE = 1,
  parameter int TIMEOUT_CYC = 64,
  localparam int VEC_W = (N <= 1) ? 1 : $clog2(N),
  localparam int PW = (PRIO_W < 1) ? 1 : PRIO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     irq_en,
  input  logic [N*PW-1:0]  prio_cfg,
  output logic             irq_valid,
  output logic [VEC_W-1:0] irq_vector,
  output logic [PW-1:0]    irq_prio,
  output logic [N-1:0]     irq_pending,
  input  logic             irq_ack,
  input  logic [VEC_W-1:0] irq_ack_vector,
  output logic             ack_err,
  output logic             timeout_err
);
  localparam logic [1:0] IDLE = 2'd0, PRESENT = 2'd1, GAP = 2'd2;
  logic [1:0] state;
  logic [N-1:0] req_q, pending, pending_nxt, elig, clr;
  logic [N*PW-1:0] prio_eff;
  logic [VEC_W-1:0] win;
  logic [PW-1:0] win_p;
  logic found, hit, to, load;
  assign prio_eff = (PRIO_W == 0) ? '0 : prio_cfg;
  assign elig = pending & irq_en;
  assign irq_pending = elig;
  assign irq_valid = state == PRESENT;
  assign hit = irq_valid && irq_ack && irq_ack_vector == irq_vector;
  assign load = !irq_valid && |elig;
  // scanning upward with a strict compare keeps the lowest index on ties
  always_comb begin
    win = '0;
    win_p = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      if (elig[i] && (!found || prio_eff[i*PW +: PW] > win_p)) begin
        found = 1'b1;
        win = VEC_W'(i);
        win_p = prio_eff[i*PW +: PW];
      end
  end
  // a new edge in the ack cycle re-sets the bit, so set wins over clear
  assign clr = (hit && EDGE_MODE != 0) ? (N'(1) << irq_ack_vector) : '0;
  assign pending_nxt = (EDGE_MODE != 0) ? ((pending & ~clr) | (req & ~req_q)) : req;
`ifdef IRQ_SRC_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] cnt;
  assign to = irq_valid && cnt == T_LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (irq_valid && !hit && !to) ? cnt + 1'b1 : '0;
      timeout_err <= timeout_err | (to && !hit);
    end
`else
  assign to = 1'b0;
  assign timeout_err = 1'b0;
`endif
  // GAP re-arbitrates directly so valid stays low for exactly one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      req_q <= '0;
      pending <= '0;
      irq_vector <= '0;
      irq_prio <= '0;
      ack_err <= 1'b0;
    end else begin
      req_q <= req;
      pending <= pending_nxt;
      state <= load ? PRESENT : (irq_valid && (hit || to)) ? GAP : (state == GAP) ? IDLE : state;
      irq_vector <= load ? win : irq_vector;
      irq_prio <= load ? win_p : irq_prio;
      ack_err <= ack_err | (irq_ack && !hit);
    end
endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb_irq_source_ctrl: directed checks of irq_source_ctrl with N=8, PRIO_W=2, edge mode
module tb_irq_source_ctrl;
  logic clk = 1'b0, rst_n;
  logic [7:0] req, irq_en, irq_pending;
  logic [15:0] prio_cfg;
  logic irq_valid, irq_ack, ack_err, timeout_err;
  logic [2:0] irq_vector, irq_ack_vector;
  logic [1:0] irq_prio;
  int tests = 0, fails = 0;
  irq_source_ctrl #(.N(8), .PRIO_W(2), .EDGE_MODE(1), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .irq_en(irq_en), .prio_cfg(prio_cfg),
    .irq_valid(irq_valid), .irq_vector(irq_vector), .irq_prio(irq_prio),
    .irq_pending(irq_pending), .irq_ack(irq_ack), .irq_ack_vector(irq_ack_vector),
    .ack_err(ack_err), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ack(input logic [2:0] v);
    irq_ack = 1'b1;
    irq_ack_vector = v;
    tick();
    irq_ack = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; req = '0; irq_en = 8'hFF; prio_cfg = '0; irq_ack = 1'b0; irq_ack_vector = '0;
    #1;
    chk("rst_valid", irq_valid, 0);
    chk("rst_pending", irq_pending, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_timeout", timeout_err, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // 1: single source
    prio_cfg = 16'h0010;
    req = 8'h04; tick(); req = 8'h00;
    chk("t1_pending", irq_pending, 8'h04);
    chk("t1_valid_early", irq_valid, 0);
    tick();
    chk("t1_valid", irq_valid, 1);
    chk("t1_vector", irq_vector, 2);
    chk("t1_prio", irq_prio, 1);
    ack(3'd2);
    chk("t1_pend_clr", irq_pending, 0);
    chk("t1_valid_low", irq_valid, 0);
    tick(); tick();
    chk("t1_idle", irq_valid, 0);
    // 2: priority order, one-cycle gap
    prio_cfg = 16'h0801;
    req = 8'h21; tick(); req = 8'h00;
    chk("t2_pending", irq_pending, 8'h21);
    tick();
    chk("t2_vec5", irq_vector, 5);
    chk("t2_prio5", irq_prio, 2);
    ack(3'd5);
    chk("t2_gap", irq_valid, 0);
    chk("t2_pend", irq_pending, 8'h01);
    tick();
    chk("t2_valid0", irq_valid, 1);
    chk("t2_vec0", irq_vector, 0);
    chk("t2_prio0", irq_prio, 1);
    ack(3'd0);
    tick();
    chk("t2_idle", irq_valid, 0);
    // 3: tie -> lowest index, mismatched ack
    prio_cfg = 16'h2080;
    req = 8'h48; tick(); req = 8'h00; tick();
    chk("t3_vec3", irq_vector, 3);
    ack(3'd6);
    chk("t3_ack_err", ack_err, 1);
    chk("t3_hold_vec", irq_vector, 3);
    chk("t3_hold_valid", irq_valid, 1);
    chk("t3_pending", irq_pending, 8'h48);
    ack(3'd3);
    chk("t3_pend40", irq_pending, 8'h40);
    tick();
    chk("t3_vec6", irq_vector, 6);
    ack(3'd6);
    tick();
    // 4: masked source
    prio_cfg = '0;
    irq_en = 8'hEF;
    req = 8'h10; tick(); req = 8'h00;
    chk("t4_masked", irq_pending, 0);
    tick(); tick();
    chk("t4_no_valid", irq_valid, 0);
    irq_en = 8'hFF; #1;
    chk("t4_unmasked", irq_pending, 8'h10);
    tick();
    chk("t4_valid", irq_valid, 1);
    chk("t4_vec4", irq_vector, 4);
    ack(3'd4);
    tick();
    // 5: new edge coincident with ack
    req = 8'h02; tick(); req = 8'h00; tick();
    chk("t5_vec1", irq_vector, 1);
    irq_ack = 1'b1; irq_ack_vector = 3'd1; req = 8'h02;
    tick();
    irq_ack = 1'b0; req = 8'h00;
    chk("t5_gap", irq_valid, 0);
    chk("t5_pend", irq_pending, 8'h02);
    tick();
    chk("t5_repres", irq_valid, 1);
    chk("t5_vec1b", irq_vector, 1);
    // 6: async reset mid-present
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", irq_valid, 0);
    chk("t6_pending", irq_pending, 0);
    chk("t6_ack_err", ack_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    req = 8'h01; tick(); req = 8'h00; tick();
    chk("t6_present", irq_valid, 1);
`ifdef IRQ_SRC_ACK_TIMEOUT_EN
    tick(); tick(); tick();
    chk("t6_pre_to", timeout_err, 0);
    chk("t6_pre_valid", irq_valid, 1);
    tick();
    chk("t6_timeout", timeout_err, 1);
    chk("t6_to_gap", irq_valid, 0);
    tick();
    chk("t6_to_repres", irq_valid, 1);
    chk("t6_to_vec", irq_vector, 0);
`else
    repeat (10) tick();
    chk("t6_wait_valid", irq_valid, 1);
    chk("t6_no_timeout", timeout_err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
